// File: rtl/gmii_tx_fcs_gen.sv
// GMII transmit framer: preamble/SFD insertion, zero padding to a minimum
// payload length, IEEE 802.3 CRC-32 FCS append and inter-frame gap enforcement.
module gmii_tx_fcs_gen #(
    parameter bit PREAMBLE_EN = 1'b1,
    parameter int MIN_LEN     = 60,
    parameter int IFG_CYCLES  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;

    localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);
    localparam logic [7:0]  IFG_W     = 8'(IFG_CYCLES);

    state_t      state, state_d;
    logic [31:0] crc, crc_d;
    logic [15:0] count, count_d;
    logic [7:0]  sub, sub_d;       // step counter shared by PRE, FCS and IFG
    logic [7:0]  txd_d;
    logic        tx_en_d, tx_er_d, frame_done_d, underrun_d;
    logic [15:0] count_inc;
    logic [16:0] count_p1;
    logic [7:0]  fcs_byte;

    // Byte-wise 802.3 CRC update: register kept MSB-first, data bits enter LSB first.
    function automatic logic [31:0] next_crc(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04c11db7 : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    assign count_inc = (count == 16'hffff) ? count : count + 16'd1;
    assign count_p1  = {1'b0, count} + 17'd1;
    // FCS goes out complemented, top CRC bit on txd[0]
    assign fcs_byte  = ~bitrev8(crc[31:24]);
    assign in_ready  = (state == DATA);
    assign busy      = (state != IDLE);

    // Next-state and next-output decode; everything lands in registers one cycle later.
    always_comb begin
        state_d      = state;
        crc_d        = crc;
        count_d      = count;
        sub_d        = sub;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    crc_d   = 32'hffffffff;
                    count_d = 16'd0;
                    if (PREAMBLE_EN) begin
                        // first preamble byte leaves on the transition itself
                        state_d = PRE;
                        txd_d   = 8'h55;
                        tx_en_d = 1'b1;
                        sub_d   = 8'd1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            PRE: begin
                tx_en_d = 1'b1;
                if (sub == 8'd7) begin
                    txd_d   = 8'hd5;
                    state_d = DATA;
                end else begin
                    txd_d = 8'h55;
                    sub_d = sub + 8'd1;
                end
            end
            DATA: begin
                tx_en_d = 1'b1;
                if (in_valid) begin
                    txd_d   = in_data;
                    crc_d   = next_crc(in_data, crc);
                    count_d = count_inc;
                    if (in_last) begin
                        sub_d   = 8'd0;
                        state_d = (count_p1 < MIN_LEN_W) ? PAD : FCS;
                    end
                end else begin
                    // upstream starved: poison the frame and skip the FCS
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    sub_d      = 8'd0;
                    state_d    = IFG;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_d   = next_crc(8'h00, crc);
                count_d = count_inc;
                if (count_p1 >= MIN_LEN_W) state_d = FCS;
            end
            FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_byte;
                crc_d   = {crc[23:0], 8'h00};
                sub_d   = sub + 8'd1;
                if (sub == 8'd3) begin
                    frame_done_d = 1'b1;
                    sub_d        = 8'd0;
                    state_d      = IFG;
                end
            end
            IFG: begin
                sub_d = sub + 8'd1;
                if (sub + 8'd1 == IFG_W) begin
                    sub_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, CRC and registered GMII outputs; reset truncates any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            crc        <= 32'hffffffff;
            count      <= 16'd0;
            sub        <= 8'd0;
            txd        <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            crc        <= crc_d;
            count      <= count_d;
            sub        <= sub_d;
            txd        <= txd_d;
            tx_en      <= tx_en_d;
            tx_er      <= tx_er_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_fcs_gen.sv
// Bench for gmii_tx_fcs_gen: wire-level frame model with a reflected CRC-32,
// a per-cycle output comparator, and a MIN_LEN=0 instance for the check-value frame.
module tb_gmii_tx_fcs_gen;

    localparam int MIN_LEN = 60;
    localparam int IFG     = 12;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       er;
        logic       done;
        logic       un;
        logic       last;
        logic       gap_chk;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0, in_last = 1'b0, sel0 = 1'b0;
    logic       in_ready, tx_en, tx_er, busy, frame_done, underrun;
    logic [7:0] txd;
    logic       in_ready0, tx_en0, tx_er0, busy0, frame_done0, underrun0;
    logic [7:0] txd0;

    int   n_tests = 0, n_fails = 0;
    rec_t exp_q[$];
    int   frame_lens[$];
    bq_t  last_frame, cur_frame, cap0;
    int   fd0 = 0, er0 = 0;

    always #4 clk = ~clk;

    gmii_tx_fcs_gen #(.PREAMBLE_EN(1'b1), .MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid & ~sel0),
        .in_last(in_last), .in_ready(in_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er),
        .busy(busy), .frame_done(frame_done), .underrun(underrun));

    gmii_tx_fcs_gen #(.PREAMBLE_EN(1'b1), .MIN_LEN(0), .IFG_CYCLES(IFG)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid & sel0),
        .in_last(in_last), .in_ready(in_ready0), .txd(txd0), .tx_en(tx_en0), .tx_er(tx_er0),
        .busy(busy0), .frame_done(frame_done0), .underrun(underrun0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC: reflected form, polynomial 0xEDB88320, no final inversion.
    function automatic logic [31:0] crc_refl(input bq_t b, input int from);
        logic [31:0] c;
        c = 32'hffffffff;
        for (int i = from; i < b.size(); i++) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return c;
    endfunction

    // Whole frame as it must appear on the wire.
    function automatic bq_t build(input bq_t p, input int min_len);
        bq_t body, w;
        logic [31:0] f;
        body = p;
        while (body.size() < min_len) body.push_back(8'h00);
        f = ~crc_refl(body, 0);
        for (int i = 0; i < 7; i++) w.push_back(8'h55);
        w.push_back(8'hd5);
        foreach (body[i]) w.push_back(body[i]);
        for (int i = 0; i < 4; i++) w.push_back(f[8*i +: 8]);
        return w;
    endfunction

    task automatic push_rec(input logic [7:0] d, input bit er, input bit done, input bit un,
                            input bit last, input bit gap);
        rec_t r;
        r.d = d; r.er = er; r.done = done; r.un = un; r.last = last; r.gap_chk = gap;
        exp_q.push_back(r);
    endtask

    task automatic expect_frame(input bq_t w, input bit gap);
        foreach (w[i]) push_rec(w[i], 1'b0, i == w.size() - 1, 1'b0, i == w.size() - 1, (i == 0) && gap);
    endtask

    task automatic expect_underrun(input bq_t p);
        for (int i = 0; i < 7; i++) push_rec(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rec(8'hd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (p[i]) push_rec(p[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rec(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Valid/ready source; no_last leaves the frame open, hold keeps in_valid up for the next call.
    task automatic send(input bq_t p, input bit no_last, input bit hold);
        int  i, guard;
        bit  acc;
        i = 0; guard = 0;
        while (i < p.size()) begin
            in_valid = 1'b1;
            in_data  = p[i];
            in_last  = (i == p.size() - 1) && !no_last;
            @(negedge clk);
            acc = sel0 ? in_ready0 : in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
            if (guard > 2000) begin
                n_tests++; n_fails++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", i, p.size());
                break;
            end
        end
        if (!hold) begin
            in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (IFG + 2) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparator for the main instance.
    initial begin
        int   gap, flen;
        bit   prev_en, last_rec_last;
        rec_t r;
        gap = 0; flen = 0; prev_en = 0; last_rec_last = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gap = 0; flen = 0; prev_en = 0;
                cur_frame.delete();
            end else if (tx_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fails++;
                    $display("FAIL unexpected_tx: txd=%h with nothing expected", txd);
                end else begin
                    r = exp_q.pop_front();
                    if (r.gap_chk) check("ifg_gap", gap, IFG);
                    check("txd", txd, r.d);
                    check("er_done_un_busy", {tx_er, frame_done, underrun, busy},
                          {r.er, r.done, r.un, 1'b1});
                    last_rec_last = r.last;
                end
                cur_frame.push_back(txd);
                flen++; gap = 0; prev_en = 1;
            end else begin
                check("idle_outputs", {txd, tx_er, frame_done, underrun}, 0);
                if (prev_en) begin
                    check("frame_end", last_rec_last, 1);
                    frame_lens.push_back(flen);
                    last_frame = cur_frame;
                    cur_frame.delete();
                    flen = 0;
                end
                gap++; prev_en = 0;
            end
        end
    end

    // Capture of the MIN_LEN=0 instance.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (tx_en0) cap0.push_back(txd0);
            fd0 += int'(frame_done0);
            er0 += int'(tx_er0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p, q, s, w;
        logic [7:0] t1_lit [21];
        t1_lit = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hd5,
                   8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hf4, 8'hcb};

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_er", tx_er, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, underrun}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: check-value payload on the unpadded instance
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        sel0 = 1'b1;
        send(p, 1'b0, 1'b0);
        sel0 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t1_tx_en_cycles", cap0.size(), 21);
        for (int i = 0; i < 21 && i < cap0.size(); i++) check("t1_txd", cap0[i], t1_lit[i]);
        check("t1_frame_done", fd0, 1);
        check("t1_tx_er", er0, 0);
        w = build(p, 0);
        for (int i = 0; i < 21; i++) check("model_t1", w[i], t1_lit[i]);

        // T2: short payload padded to MIN_LEN
        p.delete();
        for (int i = 0; i < 14; i++) p.push_back(8'h10 + 8'(i));
        expect_frame(build(p, MIN_LEN), 1'b0);
        send(p, 1'b0, 1'b0);
        drain();
        check("t2_tx_en_cycles", frame_lens[$], 72);

        // T3: 60-byte payload, receiver-side residue over SFD-stripped stream
        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'(i * 7 + 3));
        expect_frame(build(p, MIN_LEN), 1'b0);
        send(p, 1'b0, 1'b0);
        drain();
        check("t3_tx_en_cycles", frame_lens[$], 72);
        check("t3_rx_residue", crc_refl(last_frame, 8), 32'hdebb20e3);

        // T4: starve after 20 bytes, next frame offered right after the error cycle
        p.delete();
        for (int i = 0; i < 20; i++) p.push_back(8'hc0 ^ 8'(i));
        expect_underrun(p);
        send(p, 1'b1, 1'b0);
        @(posedge clk); #1;
        q.delete();
        for (int i = 0; i < 61; i++) q.push_back(8'(255 - i));
        expect_frame(build(q, MIN_LEN), 1'b1);
        // T5: back-to-back with in_valid never dropped
        send(q, 1'b0, 1'b1);
        s.delete();
        for (int i = 0; i < 3; i++) s.push_back(8'ha0 + 8'(i));
        expect_frame(build(s, MIN_LEN), 1'b1);
        send(s, 1'b0, 1'b0);
        drain();
        check("t5_tx_en_cycles", frame_lens[$], 72);

        // T6: reset while FCS byte 2 is on the wire
        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'(i * 13));
        expect_frame(build(p, MIN_LEN), 1'b0);
        send(p, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t6_tx_en", tx_en, 0);
        check("t6_busy", busy, 0);
        check("t6_txd", txd, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        p.delete();
        for (int i = 0; i < 20; i++) p.push_back(8'h5a ^ 8'(i));
        expect_frame(build(p, MIN_LEN), 1'b0);
        send(p, 1'b0, 1'b0);
        drain();
        check("t6_tx_en_cycles", frame_lens[$], 72);
        check("t6_rx_residue", crc_refl(last_frame, 8), 32'hdebb20e3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
